// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: FSM encoding, default
// parameters, legal byte-enable patterns and the access-check helpers.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LATENCY_DEFAULT = 2;
  localparam int DEPTH_DEFAULT   = 1024;

  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_BYTE1 = 4'b0010;
  localparam logic [3:0] BE_BYTE2 = 4'b0100;
  localparam logic [3:0] BE_BYTE3 = 4'b1000;
  localparam logic [3:0] BE_HALF0 = 4'b0011;
  localparam logic [3:0] BE_HALF1 = 4'b1100;
  localparam logic [3:0] BE_WORD  = 4'b1111;

  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3,
      BE_HALF0, BE_HALF1, BE_WORD: return 1'b1;
      default:                     return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM pipeline stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  busy, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output busy, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder_array.sv
// Word-organised storage with per-byte synchronous write and combinational
// read; contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wbe,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one request in IDLE, waits
// LATENCY cycles, then pulses a response carrying load data or an error.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_DEFAULT,
  parameter int LATENCY     = LATENCY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_M1   = 4'(LATENCY - 1);
  localparam logic [30:0] DEPTH_LIM = 31'(DEPTH_WORDS);

  state_t      state, next_state;
  logic [3:0]  cnt, cnt_next;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;

  logic        accept;
  logic        eff_we;
  logic [31:0] eff_addr;
  logic [31:0] eff_wdata;
  logic [3:0]  eff_be;
  logic        eff_err;
  logic        cap_err;
  logic        mem_we;
  logic        in_resp;
  logic [31:0] mem_rdata;
  logic        addr_lsb_unused;

  assign accept = (state == IDLE) && bus.req_valid;

  // With LATENCY=1 the write edge is also the acceptance edge, so the live
  // request is used before the capture registers have been loaded.
  assign eff_we    = accept ? bus.req_we    : cap_we;
  assign eff_addr  = accept ? bus.req_addr  : cap_addr;
  assign eff_wdata = accept ? bus.req_wdata : cap_wdata;
  assign eff_be    = accept ? bus.req_be    : cap_be;

  assign eff_err = ({1'b0, eff_addr[31:2]} >= DEPTH_LIM) || !be_legal(eff_be);
  assign cap_err = ({1'b0, cap_addr[31:2]} >= DEPTH_LIM) || !be_legal(cap_be);
  assign addr_lsb_unused = ^cap_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we    <= bus.req_we;
      cap_addr  <= bus.req_addr;
      cap_wdata <= bus.req_wdata;
      cap_be    <= bus.req_be;
    end
  end

  // WAIT lasts LATENCY-1 cycles so RESP lands exactly LATENCY after acceptance.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          cnt_next   = LAT_M1;
          next_state = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign mem_we = !rst && (next_state == RESP) && (state != RESP) && eff_we && !eff_err;

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (eff_addr[AW+1:2]),
    .wdata (eff_wdata),
    .wbe   (eff_be),
    .raddr (cap_addr[AW+1:2]),
    .rdata (mem_rdata)
  );

  assign in_resp        = !rst && (state == RESP);
  assign bus.busy       = !rst && ((state == WAIT) || accept);
  assign bus.resp_valid = in_resp;
  assign bus.resp_err   = in_resp && cap_err;
  assign bus.resp_rdata = (in_resp && !cap_we && !cap_err) ? (mem_rdata & lane_mask(cap_be))
                                                           : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed scenarios plus randomized traffic
// checked against a word-array reference model.
module tb_dmem_responder;

  localparam int DEPTH      = 1024;
  localparam int LAT        = 2;
  localparam int WORDS_USED = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if bus ();
  dmem_responder_if bus1 ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  logic [31:0] model_mem [WORDS_USED];
  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic legalBe(input logic [3:0] be);
    return (be == 4'b0001) || (be == 4'b0010) || (be == 4'b0100) || (be == 4'b1000) ||
           (be == 4'b0011) || (be == 4'b1100) || (be == 4'b1111);
  endfunction

  // Reference behaviour: error check, byte-lane update for stores, masked word for loads.
  task automatic modelAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, output logic exp_err, output logic [31:0] exp_rdata);
    int idx;
    exp_err   = (addr[31:2] >= 30'(DEPTH)) || !legalBe(be);
    exp_rdata = 32'd0;
    if (!exp_err) begin
      idx = int'(addr[31:2]);
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          if (we) model_mem[idx][8*i +: 8] = wdata[8*i +: 8];
          else    exp_rdata[8*i +: 8]      = model_mem[idx][8*i +: 8];
        end
      end
    end
  endtask

  // Called just after a rising edge with the responder idle.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input string tag,
                               output logic [31:0] obs_rdata, output logic obs_err);
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          lat;
    bit          got;
    modelAccess(we, addr, wdata, be, exp_err, exp_rdata);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    @(negedge clk);
    checkOutput({tag, "_busy_accept"}, 32'(bus.busy), 32'd1);
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      @(negedge clk);
      if (bus.resp_valid) got = 1'b1;
      else checkOutput({tag, "_busy_wait"}, 32'(bus.busy), 32'd1);
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(LAT));
    obs_rdata = bus.resp_rdata;
    obs_err   = bus.resp_err;
    if (got) begin
      checkOutput({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
      checkOutput({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
      checkOutput({tag, "_busy_resp"}, 32'(bus.busy), 32'd0);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_pulse_end"}, 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] addr;
    logic [3:0]  be;

    rst = 1'b1;
    bus.req_valid = 1'b0;  bus.req_we = 1'b0;  bus.req_addr = '0;  bus.req_wdata = '0;  bus.req_be = '0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0; bus1.req_be = '0;
    repeat (2) @(posedge clk);
    #1 bus.req_valid = 1'b1;
    @(negedge clk);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_err", 32'(bus.resp_err), 32'd0);
    checkOutput("rst_rdata", bus.resp_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("post_rst_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < WORDS_USED; i++)
      applyStimulus(1'b1, 32'(i * 4), $urandom, 4'hF, "init", rd, er);

    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st_full", rd, er);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, "ld_full", rd, er);
    checkOutput("ld_full_const", rd, 32'hDEADBEEF);

    applyStimulus(1'b1, 32'h20, 32'h11223344, 4'hF, "st_base", rd, er);
    applyStimulus(1'b1, 32'h20, 32'h00AB0000, 4'b0100, "st_byte2", rd, er);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'hF, "ld_merge", rd, er);
    checkOutput("ld_merge_const", rd, 32'h11AB3344);
    applyStimulus(1'b0, 32'h23, 32'h0, 4'b1100, "ld_half1", rd, er);
    checkOutput("ld_half1_const", rd, 32'h11AB0000);

    applyStimulus(1'b0, 32'h1000, 32'h0, 4'hF, "ld_oob", rd, er);
    checkOutput("ld_oob_err_const", 32'(er), 32'd1);
    checkOutput("ld_oob_rdata_const", rd, 32'd0);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, "ld_after_oob", rd, er);
    checkOutput("ld_after_oob_const", rd, 32'hDEADBEEF);

    applyStimulus(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0101, "st_badbe", rd, er);
    checkOutput("st_badbe_err_const", 32'(er), 32'd1);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'hF, "ld_after_badbe", rd, er);
    checkOutput("ld_after_badbe_const", rd, 32'h11AB3344);

    // Store abandoned by reset while waiting.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h10;
    bus.req_wdata = 32'hCAFEF00D; bus.req_be = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("abort_no_resp", 32'(bus.resp_valid), 32'd0);
      checkOutput("abort_idle_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, "ld_after_abort", rd, er);
    checkOutput("ld_after_abort_const", rd, 32'hDEADBEEF);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0)
        addr = ((32'(DEPTH) + 32'($urandom_range(0, 4095))) << 2) | ($urandom & 32'h3);
      else
        addr = (32'($urandom_range(0, WORDS_USED - 1)) << 2) | ($urandom & 32'h3);
      be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 1) == 1 && be != 4'hF) be = 4'b0011;
      applyStimulus(1'($urandom), addr, $urandom, be, "rand", rd, er);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // LATENCY=1 instance with the request held continuously.
    bus1.req_valid = 1'b1; bus1.req_we = 1'b1; bus1.req_addr = 32'h8;
    bus1.req_wdata = 32'h12345678; bus1.req_be = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("lat1_busy", 32'(bus1.busy), (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("lat1_valid", 32'(bus1.resp_valid), (k % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput("lat1_err", 32'(bus1.resp_err), 32'd0);
      checkOutput("lat1_rdata", bus1.resp_rdata, 32'd0);
      @(posedge clk); #1;
    end
    bus1.req_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: storage depth in 32-bit words; power of two.
REQ-002 Parameter LATENCY, default 2: cycles from acceptance to response; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_valid  input  1  MEM-stage access request; held stable with all req_* while busy is high.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, little-endian byte lanes.
REQ-009 req_be  input  4  byte enables; lane i = bits 8i+7:8i.
REQ-010 busy  output  1  stall to pipeline; drives the shared pause condition.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  load data; valid only with resp_valid.
REQ-013 resp_err  output  1  access rejected; valid only with resp_valid.

Function
REQ-014 FSM states: IDLE, WAIT, RESP; registered state, combinational outputs decoded from state.
REQ-015 IDLE with req_valid=1 accepts the request: capture we/addr/wdata/be; load counter with LATENCY-1; next state WAIT, or RESP if LATENCY=1.
REQ-016 IDLE with req_valid=0: remain IDLE; no storage access.
REQ-017 WAIT: decrement counter each cycle; at counter=0 go to RESP on the next edge.
REQ-018 RESP: resp_valid=1 for exactly one cycle; next state IDLE unconditionally.
REQ-019 resp_valid rises exactly LATENCY cycles after the acceptance cycle.
REQ-020 busy = 1 in WAIT and in the acceptance cycle (IDLE with req_valid=1); busy = 0 in RESP and in idle IDLE.
REQ-021 A request is accepted only in IDLE; req_valid in RESP is ignored. Back-to-back requests incur one IDLE cycle; minimum issue interval is LATENCY+1 cycles.
REQ-022 Error conditions: word index addr[31:2] >= DEPTH_WORDS; be = 0000; be not in {0001,0010,0100,1000,0011,1100,1111}.
REQ-023 On error: no storage write; resp_rdata = 0; resp_err = 1 with resp_valid.
REQ-024 Store: on the edge entering RESP, write only the enabled byte lanes of word addr[31:2]. Disabled lanes are unchanged. resp_rdata = 0.
REQ-025 Load: resp_rdata = full 32-bit word at addr[31:2]. Disabled lanes are zeroed. No sign/zero extension; extension belongs to the writeback path.
REQ-026 addr[1:0] is ignored for lane selection; lanes come from be only.
REQ-027 Outside RESP: resp_valid = 0, resp_err = 0, resp_rdata = 0.

Reset
REQ-028 rst=1 at an edge forces state IDLE and counter 0, overriding any other transition.
REQ-029 During and after reset: busy = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0.
REQ-030 A request abandoned by reset while in WAIT performs no write and produces no response.
REQ-031 Storage contents are not cleared by reset.

Structure
REQ-032 State encodings, LATENCY default, and legal be patterns are defined as shared constants in const.vh.
REQ-033 Storage is one sub-module, dmem_array: synchronous per-byte write, combinational read, DEPTH_WORDS parameter.
REQ-034 The FSM, counter, request capture registers, and error check reside in dmem_responder.

Verification
REQ-035 Reset, then store addr=0x10, be=1111, wdata=0xDEADBEEF (LATENCY=2), then load addr=0x10 -> resp_valid 2 cycles after each acceptance; load rdata = 0xDEADBEEF; resp_err = 0.
REQ-036 Store be=0100, wdata=0x00AB0000 over word 0x11223344, then load be=1111 -> rdata = 0x11AB3344.
REQ-037 Load addr=0x1000 with DEPTH_WORDS=1024 -> resp_err = 1, rdata = 0; a following valid load is unaffected.
REQ-038 Store be=0101 -> resp_err = 1; memory unchanged on read-back.
REQ-039 Store accepted, rst pulsed during WAIT -> no resp_valid; busy = 0 after reset; read-back shows old data.
REQ-040 req_valid held high continuously with LATENCY=1 -> resp_valid every 2nd cycle; busy pattern 1,0,1,0.
